// File: rtl/except_redirect.sv
// except_redirect: registered exception / ERET redirect controller.
// Captures an exception or ERET from MEM, holds a redirect request for the
// fetch PC mux until accepted, then flushes IF..MEM for FLUSH_CYCLES cycles.
// One further event arriving while busy is held in a one-deep pending slot.
// Build option: define EXC_INT_VEC_EN to send interrupts (code 0x01) to
// BEV_BASE+INT_OFFSET instead of the general vector.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no request outstanding
// S_REQ   | redirect_valid high, waiting for fetch_ready
// S_DRAIN | flush high, flush counter running down to 1

module except_redirect #(
  parameter logic [31:0] BEV_BASE     = 32'hBFC0_0000,
  parameter logic [31:0] GEN_OFFSET   = 32'h0000_0380,
  parameter logic [31:0] INT_OFFSET   = 32'h0000_0400,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             exc_valid,
  input  logic [31:0]      excepttype,
  input  logic [31:0]      epc,
  input  logic             fetch_ready,
  output logic             redirect_valid,
  output logic [31:0]      newpc,
  output logic             flush,
  output logic             busy,
  output logic             overflow,
  output logic [CNT_W-1:0] exc_count
);

  localparam logic [31:0] GEN_VEC  = BEV_BASE + GEN_OFFSET;
  localparam logic [3:0]  FLUSH_LD = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic [3:0]       r_flush_cnt;
  logic             r_pend_vld;
  logic [31:0]      r_pend_pc;
  logic [31:0]      r_newpc;
  logic             r_redirect_valid;
  logic             r_flush;
  logic             r_busy;
  logic             r_overflow;
  logic [CNT_W-1:0] r_exc_count;

  logic             w_event;
  logic             w_is_eret;
  logic [31:0]      w_target;
  logic             w_drain_last;
  logic             w_accept;
  logic             w_store;
  logic             w_drop;
  logic             w_cnt_inc;

  // Classify the incoming event and compute its redirect target.
  always_comb begin
    w_event   = exc_valid && (excepttype != 32'd0);
    w_is_eret = (excepttype == 32'h0000_000e);
    w_target  = GEN_VEC;
    if (w_is_eret) begin
      w_target = epc;
    end
`ifdef EXC_INT_VEC_EN
    else if (excepttype == 32'h0000_0001) begin
      w_target = BEV_BASE + INT_OFFSET;
    end
`endif
  end

  // Decide whether the event is taken, parked in the slot, or dropped.
  // A slot being drained this cycle still counts as full.
  always_comb begin
    w_drain_last = (r_state == S_DRAIN) && (r_flush_cnt == 4'd1);
    w_accept     = w_event && ((r_state == S_IDLE) || !r_pend_vld);
    w_store      = w_event && (r_state != S_IDLE) && !r_pend_vld && !w_drain_last;
    w_drop       = w_event && (r_state != S_IDLE) && r_pend_vld;
    w_cnt_inc    = w_accept && !w_is_eret && !(&r_exc_count);
  end

  // Redirect FSM with registered outputs, pending slot and status.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state          <= S_IDLE;
      r_flush_cnt      <= 4'd0;
      r_pend_vld       <= 1'b0;
      r_pend_pc        <= 32'd0;
      r_newpc          <= 32'd0;
      r_redirect_valid <= 1'b0;
      r_flush          <= 1'b0;
      r_busy           <= 1'b0;
      r_overflow       <= 1'b0;
      r_exc_count      <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_cnt_inc) begin
        r_exc_count <= r_exc_count + 1'b1;
      end
      if (w_store) begin
        r_pend_vld <= 1'b1;
        r_pend_pc  <= w_target;
      end
      case (r_state)
        S_IDLE: begin
          if (w_event) begin
            r_state          <= S_REQ;
            r_newpc          <= w_target;
            r_redirect_valid <= 1'b1;
            r_busy           <= 1'b1;
          end
        end
        S_REQ: begin
          if (fetch_ready) begin
            r_state          <= S_DRAIN;
            r_redirect_valid <= 1'b0;
            r_flush          <= 1'b1;
            r_flush_cnt      <= FLUSH_LD;
          end
        end
        S_DRAIN: begin
          if (r_flush_cnt == 4'd1) begin
            r_flush     <= 1'b0;
            r_flush_cnt <= 4'd0;
            if (r_pend_vld) begin
              r_state          <= S_REQ;
              r_newpc          <= r_pend_pc;
              r_redirect_valid <= 1'b1;
              r_pend_vld       <= 1'b0;
            end else if (w_event) begin
              // empty slot on the final drain cycle: take the event directly
              r_state          <= S_REQ;
              r_newpc          <= w_target;
              r_redirect_valid <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
          end
        end
        default: begin
          r_state          <= S_IDLE;
          r_redirect_valid <= 1'b0;
          r_flush          <= 1'b0;
          r_busy           <= 1'b0;
        end
      endcase
    end
  end

  assign redirect_valid = r_redirect_valid;
  assign newpc          = r_newpc;
  assign flush          = r_flush;
  assign busy           = r_busy;
  assign overflow       = r_overflow;
  assign exc_count      = r_exc_count;

endmodule

// File: tb/tb_except_redirect.sv
// Testbench for except_redirect: two instances (FLUSH_CYCLES=1/CNT_W=16 and
// FLUSH_CYCLES=3/CNT_W=4) share one stimulus stream. A queue-based reference
// model tracks outstanding redirects; accepted targets go to a scoreboard that
// the monitor pops on each observed fetch handshake.

module tb_except_redirect;

  logic        clk;
  logic        resetn;
  logic        exc_valid;
  logic [31:0] excepttype;
  logic [31:0] epc;
  logic        fetch_ready;

  logic [1:0]        rv;
  logic [1:0][31:0]  pc;
  logic [1:0]        fl;
  logic [1:0]        bz;
  logic [1:0]        ov;
  logic [15:0]       cnt0;
  logic [3:0]        cnt1;

  int n_checks = 0;
  int n_err    = 0;

  except_redirect #(.FLUSH_CYCLES(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .resetn(resetn), .exc_valid(exc_valid), .excepttype(excepttype),
    .epc(epc), .fetch_ready(fetch_ready), .redirect_valid(rv[0]), .newpc(pc[0]),
    .flush(fl[0]), .busy(bz[0]), .overflow(ov[0]), .exc_count(cnt0)
  );

  except_redirect #(.FLUSH_CYCLES(3), .CNT_W(4)) u_dut1 (
    .clk(clk), .resetn(resetn), .exc_valid(exc_valid), .excepttype(excepttype),
    .epc(epc), .fetch_ready(fetch_ready), .redirect_valid(rv[1]), .newpc(pc[1]),
    .flush(fl[1]), .busy(bz[1]), .overflow(ov[1]), .exc_count(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_target(input logic [31:0] c, input logic [31:0] e);
    if (c == 32'h0000_000e) return e;
`ifdef EXC_INT_VEC_EN
    if (c == 32'h0000_0001) return 32'hBFC0_0400;
`endif
    return 32'hBFC0_0380;
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] @%0t: got %h expected %h", name, inst, $time, act, exp);
    end
  endtask

  // Reference model: per instance, a list of outstanding targets (current
  // request first, then the pending one) and a flush countdown.
  logic [31:0] mq   [2][2];
  int          msz  [2];
  int          mdl  [2];
  int          mcnt [2];
  logic        movf [2];
  logic [31:0] mpc  [2];
  int          mflc [2];
  int          mcmax[2];
  logic [31:0] sb0 [$];
  logic [31:0] sb1 [$];
  logic        s_rv [2];
  logic [31:0] s_pc [2];

  initial begin
    mflc[0] = 1;  mcmax[0] = 65535;
    mflc[1] = 3;  mcmax[1] = 15;
    for (int i = 0; i < 2; i++) begin
      msz[i] = 0; mdl[i] = 0; mcnt[i] = 0; movf[i] = 1'b0; mpc[i] = 32'd0;
      s_rv[i] = 1'b0; s_pc[i] = 32'd0;
    end
  end

  // Monitor: advance the model on each edge, pop the scoreboard on observed
  // handshakes, then compare DUT outputs shortly after the edge.
  always @(posedge clk) begin
    logic        ev;
    logic        eret;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic        have;
    int          pre;
    logic [31:0] act_cnt;
    ev   = exc_valid && (excepttype != 32'd0);
    eret = (excepttype == 32'h0000_000e);
    tgt  = ref_target(excepttype, epc);
    for (int i = 0; i < 2; i++) begin
      if (!resetn) begin
        msz[i] = 0; mdl[i] = 0; mcnt[i] = 0; movf[i] = 1'b0; mpc[i] = 32'd0;
        if (i == 0) sb0.delete(); else sb1.delete();
      end else begin
        if (s_rv[i] && fetch_ready) begin
          have = 1'b0; exp_pc = 32'd0;
          if (i == 0 && sb0.size() > 0) begin exp_pc = sb0.pop_front(); have = 1'b1; end
          if (i == 1 && sb1.size() > 0) begin exp_pc = sb1.pop_front(); have = 1'b1; end
          if (!have) begin
            n_checks++; n_err++;
            $display("FAIL transfer[%0d] @%0t: got redirect to %h expected none", i, $time, s_pc[i]);
          end else begin
            chk("transfer_pc", i, s_pc[i], exp_pc);
          end
        end
        pre = msz[i];
        if (pre > 0) begin
          if (mdl[i] == 0) begin
            if (fetch_ready) mdl[i] = mflc[i];
          end else if (mdl[i] == 1) begin
            mq[i][0] = mq[i][1];
            msz[i]   = msz[i] - 1;
            mdl[i]   = 0;
          end else begin
            mdl[i] = mdl[i] - 1;
          end
        end
        if (ev) begin
          if (pre < 2) begin
            mq[i][msz[i]] = tgt;
            msz[i] = msz[i] + 1;
            if (i == 0) sb0.push_back(tgt); else sb1.push_back(tgt);
            if (!eret && mcnt[i] < mcmax[i]) mcnt[i] = mcnt[i] + 1;
          end else begin
            movf[i] = 1'b1;
          end
        end
        if (msz[i] > 0) mpc[i] = mq[i][0];
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      act_cnt = (i == 0) ? 32'(cnt0) : 32'(cnt1);
      chk("redirect_valid", i, 32'(rv[i]), 32'((msz[i] > 0) && (mdl[i] == 0)));
      chk("flush",          i, 32'(fl[i]), 32'(mdl[i] > 0));
      chk("busy",           i, 32'(bz[i]), 32'(msz[i] > 0));
      chk("overflow",       i, 32'(ov[i]), 32'(movf[i]));
      chk("exc_count",      i, act_cnt,    32'(mcnt[i]));
      chk("newpc",          i, pc[i],      mpc[i]);
      s_rv[i] = rv[i];
      s_pc[i] = pc[i];
    end
  end

  task automatic step(input logic v, input logic [31:0] c, input logic [31:0] e, input logic fr);
    @(negedge clk);
    exc_valid = v; excepttype = c; epc = e; fetch_ready = fr;
  endtask

  task automatic idle_cycles(input int n, input logic fr);
    for (int k = 0; k < n; k++) step(1'b0, 32'd0, 32'd0, fr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; exc_valid = 1'b0; excepttype = 32'd0; epc = 32'd0; fetch_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  logic [31:0] codes [10];

  initial begin
    codes[0] = 32'h00; codes[1] = 32'h01; codes[2] = 32'h04; codes[3] = 32'h05;
    codes[4] = 32'h08; codes[5] = 32'h09; codes[6] = 32'h0a; codes[7] = 32'h0c;
    codes[8] = 32'h0e; codes[9] = 32'h03;
    resetn = 1'b0; exc_valid = 1'b0; excepttype = 32'd0; epc = 32'd0; fetch_ready = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Sys from IDLE with fetch ready
    step(1'b1, 32'h08, 32'h0, 1'b1);
    idle_cycles(6, 1'b1);

    // ERET with fetch_ready low for three cycles
    step(1'b1, 32'h0e, 32'h8000_1234, 1'b0);
    idle_cycles(3, 1'b0);
    idle_cycles(6, 1'b1);

    // interrupt
    step(1'b1, 32'h01, 32'h0, 1'b1);
    idle_cycles(6, 1'b1);

    // pending slot and overflow
    do_reset();
    step(1'b1, 32'h08, 32'h0, 1'b0);
    step(1'b1, 32'h0c, 32'h0, 1'b0);
    step(1'b1, 32'h05, 32'h0, 1'b0);
    idle_cycles(12, 1'b1);

    // zero code ignored, then reset mid-DRAIN
    step(1'b1, 32'h00, 32'h0, 1'b1);
    idle_cycles(2, 1'b1);
    step(1'b1, 32'h04, 32'h0, 1'b1);
    idle_cycles(2, 1'b1);
    do_reset();
    idle_cycles(2, 1'b1);

    // saturate the narrow counter with back-to-back AdEL
    for (int k = 0; k < 40; k++) step(1'b1, 32'h04, 32'h0, 1'b1);
    idle_cycles(8, 1'b1);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 99) < 45), codes[$urandom_range(0, 9)],
             $urandom(), ($urandom_range(0, 99) < 55));
      end
    end
    idle_cycles(10, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
